spi_cmd: RTL and testbench

SPI_CMD -- requirements
Module: spi_cmd

---
 rtl/spi_cmd_pkg.sv | 23 ++
 rtl/sync2.sv | 28 ++
 rtl/spi_cmd.sv | 197 +++++++++++++++++++
 tb/tb_spi_cmd.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command bridge.
// Opcodes, FSM states and the bus address width.
package spi_cmd_pkg;

    localparam int ADDR_WIDTH = 17;

    typedef enum logic [1:0] {
        OP_WRITE      = 2'b00,
        OP_READ       = 2'b01,
        OP_WRITE_NEXT = 2'b10,
        OP_READ_NEXT  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_BUS     = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops reset to RST_VAL so leaving reset produces no edge.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the async input through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_cmd.sv
// SPI command decoder driving a simple req/ack bus.
// Bytes arrive from the SCLK domain; everything else runs on clk_sys.
module spi_cmd
    import spi_cmd_pkg::*;
(
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  spi_cs_n,
    input  logic [7:0]            spi_rx_byte,
    input  logic                  spi_valid,
    output logic [7:0]            spi_tx_byte,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    output logic                  bus_rw_n,
    output logic                  bus_req,
    input  logic                  bus_ack,
    input  logic [7:0]            bus_rd_data,
    output logic                  overrun
);

    logic valid_s;
    logic cs_s;
    logic valid_s_q;
    logic cs_s_q;
    logic byte_stb;
    logic cs_rise;
    logic take;
    logic ack_ok;
    logic enter_bus;
    op_e  cmd_op;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] tgt_addr_q, tgt_addr_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [7:0]            bus_wr_data_q, bus_wr_data_d;
    logic                  bus_rw_n_q, bus_rw_n_d;
    logic                  bus_req_q, bus_req_d;
    logic [7:0]            tx_q, tx_d;
    logic                  overrun_q, overrun_d;
    logic                  abort_q, abort_d;

    sync2 #(.RST_VAL(1'b0)) u_sync_valid (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .d     (spi_valid),
        .q     (valid_s)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .d     (spi_cs_n),
        .q     (cs_s)
    );

    assign byte_stb  = valid_s & ~valid_s_q;
    assign cs_rise   = cs_s & ~cs_s_q;
    assign take      = byte_stb & ~cs_rise;
    assign ack_ok    = bus_ack & bus_req_q;
    assign cmd_op    = op_e'(spi_rx_byte[7:6]);
    assign next_addr = bus_addr_q + 1'b1;

    // State and datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            valid_s_q     <= 1'b0;
            cs_s_q        <= 1'b1;
            state_q       <= ST_IDLE;
            op_q          <= OP_WRITE;
            tgt_addr_q    <= '0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            bus_rw_n_q    <= 1'b1;
            bus_req_q     <= 1'b0;
            tx_q          <= '0;
            overrun_q     <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            valid_s_q     <= valid_s;
            cs_s_q        <= cs_s;
            state_q       <= state_d;
            op_q          <= op_d;
            tgt_addr_q    <= tgt_addr_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_rw_n_q    <= bus_rw_n_d;
            bus_req_q     <= bus_req_d;
            tx_q          <= tx_d;
            overrun_q     <= overrun_d;
            abort_q       <= abort_d;
        end
    end

    // Next-state: byte-driven walk, bus completion, cs_n abort
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (byte_stb) begin
                    unique case (cmd_op)
                        OP_WRITE, OP_READ: state_d = ST_ADDR_HI;
                        OP_WRITE_NEXT:     state_d = ST_DATA;
                        OP_READ_NEXT:      state_d = ST_BUS;
                    endcase
                end
            end
            ST_ADDR_HI: if (byte_stb) state_d = ST_ADDR_LO;
            ST_ADDR_LO: begin
                if (byte_stb) begin
                    state_d = (op_q == OP_WRITE) ? ST_DATA : ST_BUS;
                end
            end
            ST_DATA: if (byte_stb) state_d = ST_BUS;
            ST_BUS: begin
                if (ack_ok) begin
                    state_d = (cs_rise || abort_q) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        // A pending bus cycle must finish; every other state aborts
        if (cs_rise && state_q != ST_BUS) begin
            state_d = ST_IDLE;
        end
    end

    assign enter_bus = (state_d == ST_BUS) && (state_q != ST_BUS);

    // Outputs and datapath: address capture, bus launch, tx load, flags
    always_comb begin
        op_d          = op_q;
        tgt_addr_d    = tgt_addr_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_rw_n_d    = bus_rw_n_q;
        bus_req_d     = bus_req_q;
        tx_d          = tx_q;
        overrun_d     = overrun_q;
        abort_d       = 1'b0;

        if (take && state_q == ST_IDLE) begin
            op_d = cmd_op;
            if (cmd_op[1]) begin
                tgt_addr_d = next_addr;
            end else begin
                tgt_addr_d[16] = spi_rx_byte[0];
            end
        end
        if (take && state_q == ST_ADDR_HI) begin
            tgt_addr_d[15:8] = spi_rx_byte;
        end
        if (take && state_q == ST_ADDR_LO) begin
            tgt_addr_d[7:0] = spi_rx_byte;
        end

        // Bus fields are frozen from here until the ack
        if (enter_bus) begin
            bus_addr_d = tgt_addr_d;
            bus_rw_n_d = op_d[0];
            if (state_q == ST_DATA) begin
                bus_wr_data_d = spi_rx_byte;
            end
        end

        if (bus_req_q) begin
            bus_req_d = ~bus_ack;
        end else begin
            bus_req_d = (state_q == ST_BUS);
        end

        if (ack_ok && bus_rw_n_q && !abort_q) begin
            tx_d = bus_rd_data;
        end

        if (state_q == ST_BUS && !ack_ok) begin
            abort_d = abort_q | cs_rise;
        end

        if (state_q == ST_BUS && byte_stb) begin
            overrun_d = 1'b1;
        end
        if (cs_rise) begin
            overrun_d = 1'b0;
        end
    end

    assign spi_tx_byte = tx_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign bus_rw_n    = bus_rw_n_q;
    assign bus_req     = bus_req_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_cmd.sv
// Scoreboard bench for spi_cmd.
// Stimulus pushes expected bus cycles; a monitor pops them on ack.
module tb_spi_cmd;
    import spi_cmd_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        spi_cs_n;
    logic [7:0]  spi_rx_byte;
    logic        spi_valid;
    logic [7:0]  spi_tx_byte;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_rw_n;
    logic        bus_req;
    logic        bus_ack;
    logic [7:0]  bus_rd_data;
    logic        overrun;

    typedef struct {
        logic [16:0] addr;
        logic        rw_n;
        logic [7:0]  wd;
        logic [7:0]  tx;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   ack_delay = 0;
    int   ack_cnt = 0;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] tx_model = 8'h00;
    logic post_ack = 1'b0;

    spi_cmd dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .spi_cs_n    (spi_cs_n),
        .spi_rx_byte (spi_rx_byte),
        .spi_valid   (spi_valid),
        .spi_tx_byte (spi_tx_byte),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rw_n    (bus_rw_n),
        .bus_req     (bus_req),
        .bus_ack     (bus_ack),
        .bus_rd_data (bus_rd_data),
        .overrun     (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input logic [16:0] a, input logic rw,
                                 input logic [7:0] wd, input logic [7:0] tx);
        exp_t e;
        e.addr = a;
        e.rw_n = rw;
        e.wd   = wd;
        e.tx   = tx;
        sb.push_back(e);
    endfunction

    // Bus slave: ack after ack_delay cycles of bus_req
    initial begin
        bus_ack = 1'b0;
        bus_rd_data = 8'h00;
        forever begin
            @(posedge clk_sys);
            #2;
            bus_ack = 1'b0;
            if (bus_req && reset_n) begin
                if (ack_cnt == ack_delay) begin
                    bus_ack = 1'b1;
                    bus_rd_data = rd_val;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Monitor: compare each acked bus cycle with the scoreboard head
    always @(negedge clk_sys) begin
        if (post_ack) begin
            chk("tx_byte", 32'(spi_tx_byte), 32'(cur.tx));
            chk("req_drop", 32'(bus_req), 32'd0);
            post_ack = 1'b0;
        end
        if (reset_n && bus_req && bus_ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got addr %0h want none",
                         bus_addr);
            end else begin
                cur = sb.pop_front();
                chk("bus_addr", 32'(bus_addr), 32'(cur.addr));
                chk("bus_rw_n", 32'(bus_rw_n), 32'(cur.rw_n));
                if (!cur.rw_n) begin
                    chk("wr_data", 32'(bus_wr_data), 32'(cur.wd));
                end
                post_ack = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_sys);
        #2;
        spi_rx_byte = b;
        spi_valid = 1'b1;
        repeat (4) @(posedge clk_sys);
        #2;
        spi_valid = 1'b0;
        repeat (4) @(posedge clk_sys);
    endtask

    task automatic end_frame();
        @(posedge clk_sys);
        #2;
        spi_cs_n = 1'b1;
        repeat (6) @(posedge clk_sys);
        #2;
        spi_cs_n = 1'b0;
        repeat (6) @(posedge clk_sys);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus_req) && n < 300) begin
            @(posedge clk_sys);
            n++;
        end
        repeat (3) @(posedge clk_sys);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        spi_cs_n = 1'b1;
        spi_valid = 1'b0;
        spi_rx_byte = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_rw_n", 32'(bus_rw_n), 32'd1);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_wd", 32'(bus_wr_data), 32'd0);
        chk("rst_tx", 32'(spi_tx_byte), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        #1;
        reset_n = 1'b1;
        spi_cs_n = 1'b0;
        repeat (6) @(posedge clk_sys);
        #1;
        chk("post_rst_req", 32'(bus_req), 32'd0);
        chk("post_rst_st", 32'(dut.state_q), 32'(ST_IDLE));

        // WRITE 0x08000 <= 0x5A
        push(17'h08000, 1'b0, 8'h5A, tx_model);
        send_byte(8'h00);
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h5A);
        wait_idle();
        chk("st_done", 32'(dut.state_q), 32'(ST_DONE));
        end_frame();
        chk("st_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // READ 0x1E810 -> 0xC3
        rd_val = 8'hC3;
        tx_model = 8'hC3;
        push(17'h1E810, 1'b1, 8'h00, tx_model);
        send_byte(8'h41);
        send_byte(8'hE8);
        send_byte(8'h10);
        wait_idle();
        end_frame();

        // WRITE 0x1FFFF then READ_NEXT wraps to 0
        push(17'h1FFFF, 1'b0, 8'h11, tx_model);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h11);
        wait_idle();
        end_frame();
        rd_val = 8'h3C;
        tx_model = 8'h3C;
        push(17'h00000, 1'b1, 8'h00, tx_model);
        send_byte(8'hC0);
        wait_idle();
        end_frame();

        // Extra byte while ack is held off
        ack_delay = 10;
        rd_val = 8'hA5;
        tx_model = 8'hA5;
        push(17'h00020, 1'b1, 8'h00, tx_model);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h99);
        wait_idle();
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_st", 32'(dut.state_q), 32'(ST_DONE));
        end_frame();
        chk("ovr_clr", 32'(overrun), 32'd0);
        ack_delay = 0;

        // Abort after addr_hi, then WRITE_NEXT to 0x00021
        send_byte(8'h00);
        send_byte(8'h12);
        end_frame();
        chk("abort_st", 32'(dut.state_q), 32'(ST_IDLE));
        chk("abort_req", 32'(bus_req), 32'd0);
        push(17'h00021, 1'b0, 8'h77, tx_model);
        send_byte(8'h80);
        send_byte(8'h77);
        wait_idle();
        end_frame();

        // Reset while bus_req is high
        ack_delay = 50;
        send_byte(8'hC0);
        n = 0;
        while (!bus_req && n < 100) begin
            @(posedge clk_sys);
            n++;
        end
        chk("req_seen", 32'(bus_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus_req), 32'd0);
        chk("arst_rw_n", 32'(bus_rw_n), 32'd1);
        chk("arst_addr", 32'(bus_addr), 32'd0);
        chk("arst_wd", 32'(bus_wr_data), 32'd0);
        chk("arst_tx", 32'(spi_tx_byte), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk_sys);
        #2;
        reset_n = 1'b1;
        ack_delay = 0;
        repeat (6) @(posedge clk_sys);
        #1;
        chk("rel_req", 32'(bus_req), 32'd0);
        chk("rel_st", 32'(dut.state_q), 32'(ST_IDLE));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
